button_event_scheduler: RTL and testbench

//  Collects press/release pulses and levels from N_BTN debouncer instances and classifies each hold as short or long.

---
 rtl/btn_ev_pkg.sv | 17 +
 rtl/rr_arbiter.sv | 36 +++
 rtl/button_event_scheduler.sv | 164 ++++++++++++++++
 tb/tb_button_event_scheduler.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/btn_ev_pkg.sv
// Shared event codes and per-button hold-state encoding for the button event scheduler.
package btn_ev_pkg;

    typedef enum logic [1:0] {
        EV_PRESS   = 2'b00,
        EV_LONG    = 2'b01,
        EV_RELEASE = 2'b10,
        EV_REPEAT  = 2'b11
    } ev_type_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        HELD  = 2'b01,
        LONGH = 2'b10
    } btn_st_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin request picker: first set request at or after i_ptr, returned as one-hot and as an index.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         i_req,
    input  logic [$clog2(N)-1:0] i_ptr,
    output logic [N-1:0]         o_grant,
    output logic [$clog2(N)-1:0] o_idx,
    output logic                 o_found
);

    localparam int          IW  = $clog2(N);
    localparam logic [IW:0] N_W = (IW+1)'(N);

    logic [IW:0] w_pos;

    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        w_pos   = '0;
        for (int k = 0; k < N; k++) begin
            // modulo-N walk so non-power-of-two N also wraps correctly
            w_pos = {1'b0, i_ptr} + (IW+1)'(k);
            if (w_pos >= N_W) begin
                w_pos = w_pos - N_W;
            end
            if (!o_found && i_req[w_pos[IW-1:0]]) begin
                o_found = 1'b1;
                o_idx   = w_pos[IW-1:0];
            end
        end
        o_grant        = '0;
        o_grant[o_idx] = o_found;
    end

endmodule

// File: rtl/button_event_scheduler.sv
// Classifies debounced button holds into PRESS/LONG/RELEASE(/REPEAT) events and arbitrates them onto one valid/ready stream.
// Optional: define BUTTON_AUTO_REPEAT_EN to emit periodic REPEAT events while a button stays in the long-hold state.
module button_event_scheduler
    import btn_ev_pkg::*;
#(
    parameter int N_BTN        = 4,
    parameter int LONG_TICKS   = 50_000_000,
    parameter int REPEAT_TICKS = 10_000_000,
    parameter int CNT_W        = 26
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_BTN-1:0]         btn_state,
    input  logic [N_BTN-1:0]         btn_up,
    input  logic [N_BTN-1:0]         btn_dn,
    output logic                     ev_valid,
    input  logic                     ev_ready,
    output logic [$clog2(N_BTN)-1:0] ev_btn,
    output logic [1:0]               ev_type,
    output logic                     ev_drop
);

    localparam int               IDX_W     = $clog2(N_BTN);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_TICKS - 1);
`ifdef BUTTON_AUTO_REPEAT_EN
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_TICKS - 1);
`endif
    localparam longint MAX_TICKS = (LONG_TICKS > REPEAT_TICKS) ? longint'(LONG_TICKS)
                                                               : longint'(REPEAT_TICKS);

    if (MAX_TICKS > (longint'(1) << CNT_W)) begin : g_cnt_w_check
        $error("CNT_W too narrow for LONG_TICKS/REPEAT_TICKS");
    end

    logic [N_BTN-1:0] w_req;
    logic [N_BTN-1:0] w_gnt_raw;
    logic [N_BTN-1:0] w_grant;
    logic [N_BTN-1:0] w_drop;
    logic [1:0]       w_pend_type [N_BTN];
    logic [IDX_W-1:0] w_idx;
    logic             w_found;
    logic             w_load;

    logic             r_valid;
    logic [IDX_W-1:0] r_btn;
    logic [1:0]       r_type;
    logic [IDX_W-1:0] r_ptr;

    assign w_load  = ~r_valid | ev_ready;
    assign w_grant = w_load ? w_gnt_raw : '0;

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        btn_st_t          r_state;
        logic [CNT_W-1:0] r_cnt;
        logic             r_pend_v;
        logic [1:0]       r_pend_type;
        logic             r_drop;
        logic             w_busy;

        // slot still occupied after this cycle's grant -> a new event overwrites it
        assign w_busy = r_pend_v & ~w_grant[i];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_state     <= IDLE;
                r_cnt       <= '0;
                r_pend_v    <= 1'b0;
                r_pend_type <= EV_PRESS;
                r_drop      <= 1'b0;
            end else begin
                r_drop <= 1'b0;
                if (w_grant[i]) begin
                    r_pend_v <= 1'b0;
                end
                case (r_state)
                    IDLE: begin
                        if (btn_up[i]) begin
                            r_state     <= HELD;
                            r_cnt       <= '0;
                            r_pend_v    <= 1'b1;
                            r_pend_type <= EV_PRESS;
                            r_drop      <= w_busy;
                        end
                    end
                    HELD, LONGH: begin
                        if (btn_dn[i]) begin
                            r_state     <= IDLE;
                            r_cnt       <= '0;
                            r_pend_v    <= 1'b1;
                            r_pend_type <= EV_RELEASE;
                            r_drop      <= w_busy;
                        end else if (!btn_state[i]) begin
                            r_state <= IDLE;
                            r_cnt   <= '0;
                        end else if (r_state == HELD) begin
                            if (r_cnt == LONG_LAST) begin
                                r_state     <= LONGH;
                                r_cnt       <= '0;
                                r_pend_v    <= 1'b1;
                                r_pend_type <= EV_LONG;
                                r_drop      <= w_busy;
                            end else if (r_cnt != '1) begin
                                r_cnt <= r_cnt + 1'b1;
                            end
                        end else begin
`ifdef BUTTON_AUTO_REPEAT_EN
                            if (r_cnt == REP_LAST) begin
                                r_cnt       <= '0;
                                r_pend_v    <= 1'b1;
                                r_pend_type <= EV_REPEAT;
                                r_drop      <= w_busy;
                            end else if (r_cnt != '1) begin
                                r_cnt <= r_cnt + 1'b1;
                            end
`else
                            r_cnt <= '0;
`endif
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end
                endcase
            end
        end

        assign w_req[i]       = r_pend_v;
        assign w_pend_type[i] = r_pend_type;
        assign w_drop[i]      = r_drop;
    end

    rr_arbiter #(
        .N (N_BTN)
    ) u_arb (
        .i_req   (w_req),
        .i_ptr   (r_ptr),
        .o_grant (w_gnt_raw),
        .o_idx   (w_idx),
        .o_found (w_found)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_btn   <= '0;
            r_type  <= EV_PRESS;
            r_ptr   <= '0;
        end else if (w_load) begin
            r_valid <= w_found;
            if (w_found) begin
                r_btn  <= w_idx;
                r_type <= w_pend_type[w_idx];
                r_ptr  <= (w_idx == IDX_W'(N_BTN - 1)) ? '0 : w_idx + 1'b1;
            end
        end
    end

    assign ev_valid = r_valid;
    assign ev_btn   = r_btn;
    assign ev_type  = r_type;
    assign ev_drop  = |w_drop;

endmodule

// File: tb/tb_button_event_scheduler.sv
// Self-checking bench for button_event_scheduler: table-driven stimulus feeding an event scoreboard, plus timing/stall/reset sequences.
module tb_button_event_scheduler;
    import btn_ev_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] btn_state = '0;
    logic [3:0] btn_up = '0;
    logic [3:0] btn_dn = '0;
    logic       ev_ready = 1'b1;
    logic       ev_valid;
    logic [1:0] ev_btn;
    logic [1:0] ev_type;
    logic       ev_drop;

    int total = 0;
    int bad = 0;
    int drop_seen = 0;
    int valid_seen = 0;

    typedef struct packed {
        logic [1:0] btn;
        logic [1:0] typ;
    } ev_t;

    typedef struct packed {
        logic [3:0] up;
        logic [3:0] dn;
        logic [3:0] st;
        logic [4:0] idle;
        logic [2:0] n;
        logic [7:0] btns;
        logic [7:0] typs;
    } vec_t;

`ifdef BUTTON_AUTO_REPEAT_EN
    localparam int REP_N = 4;
`else
    localparam int REP_N = 2;
`endif

    ev_t exp_q[$];
    ev_t mon_e;

    button_event_scheduler #(
        .N_BTN        (4),
        .LONG_TICKS   (8),
        .REPEAT_TICKS (4),
        .CNT_W        (26)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_state (btn_state),
        .btn_up    (btn_up),
        .btn_dn    (btn_dn),
        .ev_valid  (ev_valid),
        .ev_ready  (ev_ready),
        .ev_btn    (ev_btn),
        .ev_type   (ev_type),
        .ev_drop   (ev_drop)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h", nm, act, want);
        end
    endtask

    task automatic drive(input logic [3:0] up, input logic [3:0] dn, input logic [3:0] st);
        btn_up    = up;
        btn_dn    = dn;
        btn_state = st;
        @(posedge clk);
        #1;
        btn_up = '0;
        btn_dn = '0;
    endtask

    function automatic vec_t mk(input logic [3:0] up, input logic [3:0] dn, input logic [3:0] st,
                                input int idle, input int n, input logic [7:0] btns,
                                input logic [7:0] typs);
        vec_t v;
        v.up   = up;
        v.dn   = dn;
        v.st   = st;
        v.idle = 5'(idle);
        v.n    = 3'(n);
        v.btns = btns;
        v.typs = typs;
        return v;
    endfunction

    // scoreboard: every accepted event must match the oldest expectation
    always @(negedge clk) begin
        if (ev_drop) drop_seen++;
        if (ev_valid) valid_seen++;
        if (ev_valid && ev_ready && !rst) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_event: got btn=%0d type=%0d, want none", ev_btn, ev_type);
            end else begin
                mon_e = exp_q.pop_front();
                chk("event", {28'd0, ev_btn, ev_type}, {28'd0, mon_e.btn, mon_e.typ});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t tbl [16];
        // events listed oldest first, two bits per entry in btns/typs
        tbl[0]  = mk(4'hF, 4'h0, 4'hF, 4,  4,     8'hE4, 8'h00);
        tbl[1]  = mk(4'h0, 4'hF, 4'h0, 5,  4,     8'hE4, 8'hAA);
        tbl[2]  = mk(4'h1, 4'h0, 4'h1, 2,  1,     8'h00, 8'h00);
        tbl[3]  = mk(4'h0, 4'h1, 4'h0, 2,  1,     8'h00, 8'h02);
        tbl[4]  = mk(4'h4, 4'h0, 4'h4, 19, REP_N, 8'hAA, 8'hF4);
        tbl[5]  = mk(4'h0, 4'h4, 4'h0, 3,  1,     8'h02, 8'h02);
        tbl[6]  = mk(4'h0, 4'h4, 4'h0, 2,  0,     8'h00, 8'h00);
        tbl[7]  = mk(4'h4, 4'h0, 4'h4, 2,  1,     8'h02, 8'h00);
        tbl[8]  = mk(4'h4, 4'h0, 4'h4, 2,  0,     8'h00, 8'h00);
        tbl[9]  = mk(4'h0, 4'h4, 4'h0, 3,  1,     8'h02, 8'h02);
        tbl[10] = mk(4'h8, 4'h0, 4'h8, 2,  1,     8'h03, 8'h00);
        tbl[11] = mk(4'h0, 4'h0, 4'h0, 12, 0,     8'h00, 8'h00);
        tbl[12] = mk(4'h1, 4'h0, 4'h1, 0,  1,     8'h00, 8'h00);
        tbl[13] = mk(4'h0, 4'h1, 4'h0, 3,  1,     8'h00, 8'h02);
        tbl[14] = mk(4'h2, 4'h0, 4'h2, 9,  2,     8'h05, 8'h04);
        tbl[15] = mk(4'h0, 4'h2, 4'h0, 3,  1,     8'h01, 8'h02);

        // reset state
        @(posedge clk);
        @(negedge clk);
        chk("reset_out", {26'd0, ev_valid, ev_btn, ev_type, ev_drop}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post_reset_idle", {26'd0, ev_valid, ev_btn, ev_type, ev_drop}, 32'd0);

        // table phase, ev_ready held high
        drop_seen = 0;
        for (int r = 0; r < 16; r++) begin
            for (int k = 0; k < int'(tbl[r].n); k++) begin
                exp_q.push_back(ev_t'({tbl[r].btns[2*k +: 2], tbl[r].typs[2*k +: 2]}));
            end
            drive(tbl[r].up, tbl[r].dn, tbl[r].st);
            for (int c = 0; c < int'(tbl[r].idle); c++) begin
                drive(4'h0, 4'h0, tbl[r].st);
            end
        end
        for (int c = 0; c < 20 && exp_q.size() != 0; c++) @(posedge clk);
        chk("table_drained", exp_q.size(), 0);
        chk("table_no_drop", drop_seen, 0);

        // press/release latency
        exp_q.push_back(ev_t'({2'd1, EV_PRESS}));
        drive(4'b0010, 4'h0, 4'b0010);
        @(negedge clk);
        chk("t1_not_yet", {31'd0, ev_valid}, 32'd0);
        drive(4'h0, 4'h0, 4'b0010);
        @(negedge clk);
        chk("t1_press_at_t2", {27'd0, ev_valid, ev_btn, ev_type}, {27'd0, 5'b1_01_00});
        drive(4'h0, 4'h0, 4'b0010);
        exp_q.push_back(ev_t'({2'd1, EV_RELEASE}));
        drive(4'h0, 4'b0010, 4'h0);
        @(negedge clk);
        chk("t1_gap", {31'd0, ev_valid}, 32'd0);
        drive(4'h0, 4'h0, 4'h0);
        @(negedge clk);
        chk("t1_release_at_t5", {27'd0, ev_valid, ev_btn, ev_type}, {27'd0, 5'b1_01_10});
        for (int c = 0; c < 3; c++) drive(4'h0, 4'h0, 4'h0);

        // stall with overwrite of a pending slot
        ev_ready = 1'b0;
        exp_q.push_back(ev_t'({2'd1, EV_PRESS}));
        drive(4'b0010, 4'h0, 4'b0010);
        drive(4'h0, 4'h0, 4'b0010);
        @(negedge clk);
        chk("t4_hold0", {27'd0, ev_valid, ev_btn, ev_type}, {27'd0, 5'b1_01_00});
        drive(4'b0001, 4'h0, 4'b0011);
        exp_q.push_back(ev_t'({2'd0, EV_RELEASE}));
        drive(4'h0, 4'b0001, 4'b0010);
        @(negedge clk);
        chk("t4_drop", {31'd0, ev_drop}, 32'd1);
        chk("t4_hold1", {27'd0, ev_valid, ev_btn, ev_type}, {27'd0, 5'b1_01_00});
        drive(4'h0, 4'h0, 4'b0010);
        ev_ready = 1'b1;
        @(negedge clk);
        chk("t4_drop_one_cycle", {31'd0, ev_drop}, 32'd0);
        chk("t4_hold2", {27'd0, ev_valid, ev_btn, ev_type}, {27'd0, 5'b1_01_00});
        drive(4'h0, 4'h0, 4'b0010);
        exp_q.push_back(ev_t'({2'd1, EV_RELEASE}));
        drive(4'h0, 4'b0010, 4'h0);
        for (int c = 0; c < 4; c++) drive(4'h0, 4'h0, 4'h0);
        chk("t4_drained", exp_q.size(), 0);

        // reset in the middle of a hold
        ev_ready = 1'b0;
        drive(4'b1000, 4'h0, 4'b1000);
        drive(4'h0, 4'h0, 4'b1000);
        drive(4'h0, 4'h0, 4'b1000);
        @(negedge clk);
        chk("t5_pre", {29'd0, ev_valid, ev_btn}, {29'd0, 3'b1_11});
        #2 rst = 1'b1;
        #1;
        chk("t5_async_clear", {26'd0, ev_valid, ev_btn, ev_type, ev_drop}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        ev_ready   = 1'b1;
        valid_seen = 0;
        for (int c = 0; c < 12; c++) drive(4'h0, 4'h0, 4'b1000);
        chk("t5_silent_after_reset", valid_seen, 0);
        exp_q.push_back(ev_t'({2'd3, EV_PRESS}));
        drive(4'b1000, 4'h0, 4'b1000);
        for (int c = 0; c < 3; c++) drive(4'h0, 4'h0, 4'b1000);
        exp_q.push_back(ev_t'({2'd3, EV_RELEASE}));
        drive(4'h0, 4'b1000, 4'h0);
        for (int c = 0; c < 4; c++) drive(4'h0, 4'h0, 4'h0);

        for (int c = 0; c < 30 && exp_q.size() != 0; c++) @(posedge clk);
        chk("all_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
